// File: rtl/display_pkg.sv
// display_pkg -- shared definitions for the 7-segment display blocks.
//   SEG_BLANK  : all segments off (active-low outputs)
//   AN_OFF     : all anodes off (active-low outputs)
//   RING_FIRST : ring position for digit 0 (rightmost)
//   hex_to_seg : 4-bit nibble to active-low segments {g,f,e,d,c,b,a}.
//                All 16 codes decode, because the low digits are binary.
package display_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam logic [3:0] RING_FIRST = 4'b0001;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'ha:    s = 7'b0001000;
      4'hb:    s = 7'b0000011;
      4'hc:    s = 7'b1000110;
      4'hd:    s = 7'b0100001;
      4'he:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan4_if.sv
// seg7_scan4_if -- bundle between the value source and the 4-digit scanner.
//   en       : display enable (0 blanks every digit)
//   val      : 16-bit value, val[3:0] is digit 0 (rightmost)
//   dig_en   : per-digit enable, 0 blanks that digit
//   dp_in    : per-digit decimal point request, active high
//   blank_lz : 1 enables leading-zero blanking
//   an/seg/dp: active-low display drive
// There is no handshake: every signal is a clk-domain level that the
// scanner samples on every rising edge; there is no valid/ready pair.
interface seg7_scan4_if;
  logic        en;
  logic [15:0] val;
  logic [3:0]  dig_en;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output en, val, dig_en, dp_in, blank_lz,
    input  an, seg, dp
  );

  modport slave (
    input  en, val, dig_en, dp_in, blank_lz,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_prescaler.sv
// seg7_prescaler -- refresh prescaler for the digit scan.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : high for the single cycle in which the count equals
//                REFRESH_CNT-1; the count then wraps to 0.
// Runs continuously; it does not look at the display enable.
module seg7_prescaler #(
  parameter int REFRESH_CNT = 100000,
  parameter int CNT_W       = 17
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_CNT - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan4.sv
// seg7_scan4 -- time-multiplexes a 16-bit value onto a common-anode
// 4-digit 7-segment display.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg7_scan4_if slave (value/controls in, an/seg/dp out)
//   dbg_ring   : current one-hot digit ring (digit 0 = 4'b0001)
// A one-hot ring advances on each prescaler tick; the selected nibble is
// decoded, blanked if required, and registered. Outputs lag the ring and
// inputs by exactly one clock.
module seg7_scan4
  import display_pkg::*;
#(
  parameter int REFRESH_CNT = 100000,
  parameter int CNT_W       = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  seg7_scan4_if.slave  bus,
  output logic [3:0]   dbg_ring
);

  logic       tick;
  logic [3:0] ring;
  logic [1:0] sel;
  logic [3:0] nib;
  logic       lz_blank;
  logic       blank;

  seg7_prescaler #(
    .REFRESH_CNT (REFRESH_CNT),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Any non-one-hot value (e.g. after an upset) is forced back to digit 0
  // on the next tick instead of being rotated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring <= RING_FIRST;
    end else if (tick) begin
      case (ring)
        4'b0001: ring <= 4'b0010;
        4'b0010: ring <= 4'b0100;
        4'b0100: ring <= 4'b1000;
        4'b1000: ring <= 4'b0001;
        default: ring <= RING_FIRST;
      endcase
    end
  end

  assign dbg_ring = ring;

  always_comb begin
    case (ring)
      4'b0010: sel = 2'd1;
      4'b0100: sel = 2'd2;
      4'b1000: sel = 2'd3;
      default: sel = 2'd0;
    endcase
  end

  assign nib = bus.val[{sel, 2'b00} +: 4];

  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit 0 is exempt so that a value of zero still shows "0".
  always_comb begin
    case (sel)
      2'd3:    lz_blank = (bus.val[15:12] == 4'h0);
      2'd2:    lz_blank = (bus.val[15:8]  == 8'h00);
      2'd1:    lz_blank = (bus.val[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
  end

  assign blank = !bus.en || !bus.dig_en[sel] || (bus.blank_lz && lz_blank);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an  <= AN_OFF;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else if (blank) begin
      bus.an  <= AN_OFF;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= ~ring;
      bus.seg <= hex_to_seg(nib);
      bus.dp  <= ~bus.dp_in[sel];
    end
  end

endmodule
